// File: rtl/snn_pkg.sv
// Shared sizing defaults and FSM encoding for the SNN timestep scheduler.
// Pure declarations: no latency, no flow control.
package snn_pkg;

  localparam int STEP_W     = 8;
  localparam int LAYER_W    = 2;
  localparam int NUM_LAYERS = 3;
  localparam int TIMEOUT    = 1024;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    NEXT,
    FINISH
  } state_t;

endpackage

// File: rtl/snn_watchdog.sv
// Saturating cycle watchdog with clear/load; expire is combinational and fires while en on the cycle the count steps to LIMIT.
// Count holds at LIMIT; clr and load take priority over counting; no backpressure.
module snn_watchdog #(
  parameter int LIMIT = 1023,
  parameter int CW    = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          expire
);

  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] MAX  = CW'(LIMIT);

  logic [CW-1:0] cnt;

  assign expire = en && !clr && !load && (cnt >= LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/snn_step_scheduler.sv
// Walks num_steps timesteps x NUM_LAYERS layers with a layer_start/layer_done handshake; start->layer_start 1 cycle, layer_done->next layer_start 2 cycles.
// Waits on the engine indefinitely up to the TIMEOUT watchdog; abort returns to IDLE on the next cycle.
module snn_step_scheduler #(
  parameter int NUM_LAYERS = snn_pkg::NUM_LAYERS,
  parameter int STEP_W     = snn_pkg::STEP_W,
  parameter int LAYER_W    = snn_pkg::LAYER_W,
  parameter int TIMEOUT    = snn_pkg::TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [STEP_W-1:0]  num_steps,
  input  logic               abort,
  input  logic               layer_done,
  output logic               layer_start,
  output logic [LAYER_W-1:0] layer_idx,
  output logic [STEP_W-1:0]  timestep,
  output logic               step_done,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);

  import snn_pkg::*;

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  localparam int                 WD_LIMIT   = TIMEOUT - 1;
  localparam int                 WD_CW      = (WD_LIMIT < 2) ? 1 : $clog2(WD_LIMIT + 1);

  state_t            state;
  state_t            state_n;
  logic [STEP_W-1:0] steps_q;
  logic              accept;
  logic              last_layer;
  logic              last_step;
  logic              wd_clr;
  logic              wd_en;
  logic              wd_expire;

  assign accept     = (state == IDLE) && start && !abort;
  assign last_layer = (layer_idx == LAST_LAYER);
  assign last_step  = (timestep == steps_q - STEP_W'(1));
  assign wd_clr     = (state == ISSUE);
  assign wd_en      = (state == WAIT) && !layer_done && !abort;

  snn_watchdog #(
    .LIMIT (WD_LIMIT),
    .CW    (WD_CW)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (wd_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (wd_en),
    .expire   (wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = (num_steps == '0) ? FINISH : ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT: begin
        if (layer_done)     state_n = NEXT;
        else if (wd_expire) state_n = IDLE;
      end
      NEXT:    state_n = (last_layer && last_step) ? FINISH : ISSUE;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // abort overrides every transition, including a coincident layer_done
    if (abort) state_n = IDLE;
  end

  // layer_start/busy look ahead at state_n so they line up with the state;
  // step_done/done are taken from the current state and so trail it by a cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_start <= 1'b0;
      busy        <= 1'b0;
      step_done   <= 1'b0;
      done        <= 1'b0;
    end else begin
      layer_start <= (state_n == ISSUE);
      busy        <= (state_n != IDLE);
      step_done   <= (state == NEXT) && last_layer && !abort;
      done        <= (state == FINISH) && !abort;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (accept) begin
      timeout_err <= 1'b0;
    end else if (wd_expire) begin
      timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steps_q   <= '0;
      timestep  <= '0;
      layer_idx <= '0;
    end else if (accept) begin
      steps_q   <= num_steps;
      timestep  <= '0;
      layer_idx <= '0;
    end else if ((state == NEXT) && !abort) begin
      if (!last_layer) begin
        layer_idx <= layer_idx + LAYER_W'(1);
      end else begin
        layer_idx <= '0;
        // timestep parks on its final value rather than wrapping
        if (!last_step) timestep <= timestep + STEP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Bench for snn_step_scheduler: vector table, randomized jobs against a timeline model, and hand-written abort/watchdog/reset sequences.
module tb_snn_step_scheduler;

  localparam int NL = 3;
  localparam int SW = 8;
  localparam int LW = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] num_steps = '0;
  logic          abort = 1'b0;
  logic          layer_done = 1'b0;
  logic          layer_start;
  logic [LW-1:0] layer_idx;
  logic [SW-1:0] timestep;
  logic          step_done;
  logic          busy;
  logic          done;
  logic          timeout_err;

  int n_pass = 0;
  int n_total = 0;
  int dly_tab[64];

  typedef struct {
    int n;
    int d;
    bit spur;
    bit restart;
    int exp_starts;
    int exp_steps;
    int exp_done;
  } vec_t;

  snn_step_scheduler #(
    .NUM_LAYERS (NL),
    .STEP_W     (SW),
    .LAYER_W    (LW),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_steps   (num_steps),
    .abort       (abort),
    .layer_done  (layer_done),
    .layer_start (layer_start),
    .layer_idx   (layer_idx),
    .timestep    (timestep),
    .step_done   (step_done),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One job: start at cycle 0, engine answers layer k dly_tab[k] cycles after its layer_start.
  // abort_idx >= 0 aborts (with a coincident layer_done) during the WAIT of that layer.
  task automatic run_job(input string tag, input int n, input bit spur, input bit restart,
                         input int abort_idx, output int o_starts, output int o_steps, output int o_done);
    int st_cyc[$];
    int st_ts[$];
    int st_ly[$];
    int sd_cyc[$];
    int dn_cyc[$];
    int resp[$];
    int exp_cyc[$];
    int exp_ts[$];
    int exp_ly[$];
    int exp_sd[$];
    int busy_low = 0;
    int terr = 0;
    int issued = 0;
    int abort_cyc = -1;
    int busy_after_abort = -1;
    int cyc = 0;
    int t;
    int k;
    int nxt;
    int exp_done;
    bit fin = 0;
    bit stop = 0;
    while (!fin && cyc < 600) begin
      bit ld;
      if (cyc > 0) begin
        if (layer_start) begin
          st_cyc.push_back(cyc);
          st_ts.push_back(int'(timestep));
          st_ly.push_back(int'(layer_idx));
        end
        if (step_done) sd_cyc.push_back(cyc);
        if (done) dn_cyc.push_back(cyc);
        if (timeout_err) terr++;
        if (!busy && dn_cyc.size() == 0 && abort_cyc < 0) busy_low++;
        if (abort_cyc >= 0 && cyc == abort_cyc + 1) busy_after_abort = int'(busy);
      end
      ld = 1'b0;
      for (int i = resp.size() - 1; i >= 0; i--) begin
        if (resp[i] == cyc) begin
          ld = 1'b1;
          resp.delete(i);
        end
      end
      if (cyc > 0 && layer_start) begin
        if (spur) ld = 1'b1;
        if (issued == abort_idx) abort_cyc = cyc + 2;
        else resp.push_back(cyc + dly_tab[issued]);
        issued++;
      end
      abort = (cyc == abort_cyc);
      if (abort) ld = 1'b1;
      layer_done = ld;
      start = (cyc == 0) || (restart && cyc == 5);
      num_steps = (cyc == 0) ? SW'(n) : 8'd9;
      if (dn_cyc.size() > 0 || (abort_cyc >= 0 && cyc >= abort_cyc + 4)) fin = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    layer_done = 1'b0;
    chk({tag, " finished within budget"}, int'(fin), 1);

    // Timeline model: each layer occupies its response delay plus two cycles of turnaround.
    k = 0;
    t = 1;
    exp_done = (n == 0) ? 2 : -1;
    for (int s = 0; s < n && !stop; s++) begin
      for (int l = 0; l < NL && !stop; l++) begin
        exp_cyc.push_back(t);
        exp_ts.push_back(s);
        exp_ly.push_back(l);
        if (k == abort_idx) begin
          stop = 1'b1;
        end else begin
          nxt = t + dly_tab[k] + 2;
          if (l == NL - 1) exp_sd.push_back(nxt);
          if (l == NL - 1 && s == n - 1) exp_done = nxt + 1;
          t = nxt;
          k++;
        end
      end
    end

    chk({tag, " layer_start count"}, st_cyc.size(), exp_cyc.size());
    for (int i = 0; i < st_cyc.size() && i < exp_cyc.size(); i++) begin
      chk($sformatf("%s start%0d cycle", tag, i), st_cyc[i], exp_cyc[i]);
      chk($sformatf("%s start%0d timestep", tag, i), st_ts[i], exp_ts[i]);
      chk($sformatf("%s start%0d layer", tag, i), st_ly[i], exp_ly[i]);
    end
    chk({tag, " step_done count"}, sd_cyc.size(), exp_sd.size());
    for (int i = 0; i < sd_cyc.size() && i < exp_sd.size(); i++)
      chk($sformatf("%s step_done%0d cycle", tag, i), sd_cyc[i], exp_sd[i]);
    if (abort_idx < 0) begin
      chk({tag, " done count"}, dn_cyc.size(), 1);
      if (dn_cyc.size() > 0) chk({tag, " done cycle"}, dn_cyc[0], exp_done);
      chk({tag, " busy dropped early"}, busy_low, 0);
    end else begin
      chk({tag, " done count after abort"}, dn_cyc.size(), 0);
      chk({tag, " busy after abort"}, busy_after_abort, 0);
    end
    chk({tag, " timeout_err seen"}, terr, 0);
    o_starts = st_cyc.size();
    o_steps = sd_cyc.size();
    o_done = (dn_cyc.size() > 0) ? dn_cyc[0] : -1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv[6];
    int os;
    int ost;
    int od;
    int n;
    int sp;

    tv[0] = '{n: 2, d: 4, spur: 1'b0, restart: 1'b0, exp_starts: 6, exp_steps: 2, exp_done: 38};
    tv[1] = '{n: 0, d: 4, spur: 1'b0, restart: 1'b0, exp_starts: 0, exp_steps: 0, exp_done: 2};
    tv[2] = '{n: 1, d: 1, spur: 1'b0, restart: 1'b0, exp_starts: 3, exp_steps: 1, exp_done: 11};
    tv[3] = '{n: 2, d: 4, spur: 1'b0, restart: 1'b1, exp_starts: 6, exp_steps: 2, exp_done: 38};
    tv[4] = '{n: 3, d: 2, spur: 1'b1, restart: 1'b0, exp_starts: 9, exp_steps: 3, exp_done: 38};
    tv[5] = '{n: 1, d: 7, spur: 1'b0, restart: 1'b0, exp_starts: 3, exp_steps: 1, exp_done: 29};

    // reset state
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset layer_start", int'(layer_start), 0);
    chk("reset done", int'(done), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle busy", int'(busy), 0);
    chk("idle timeout_err", int'(timeout_err), 0);
    chk("idle timestep", int'(timestep), 0);
    chk("idle layer_idx", int'(layer_idx), 0);
    chk("idle step_done", int'(step_done), 0);

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 64; j++) dly_tab[j] = tv[i].d;
      run_job($sformatf("vec%0d", i), tv[i].n, tv[i].spur, tv[i].restart, -1, os, ost, od);
      chk($sformatf("vec%0d table starts", i), os, tv[i].exp_starts);
      chk($sformatf("vec%0d table steps", i), ost, tv[i].exp_steps);
      chk($sformatf("vec%0d table done cycle", i), od, tv[i].exp_done);
      tick();
      tick();
    end

    // abort together with layer_done during WAIT of (timestep 1, layer 2)
    for (int j = 0; j < 64; j++) dly_tab[j] = 4;
    run_job("abort", 2, 1'b0, 1'b0, 5, os, ost, od);
    chk("abort step_done total", ost, 1);
    tick();

    // watchdog: engine never answers
    start = 1'b1;
    num_steps = 8'd1;
    tick();
    start = 1'b0;
    chk("wd layer_start", int'(layer_start), 1);
    for (int i = 0; i < 15; i++) tick();
    chk("wd cycle16 timeout_err", int'(timeout_err), 0);
    chk("wd cycle16 busy", int'(busy), 1);
    tick();
    chk("wd cycle17 timeout_err", int'(timeout_err), 1);
    chk("wd cycle17 busy", int'(busy), 0);
    chk("wd cycle17 done", int'(done), 0);
    tick();
    chk("wd timeout_err sticky", int'(timeout_err), 1);
    for (int j = 0; j < 64; j++) dly_tab[j] = 3;
    run_job("after_wd", 1, 1'b0, 1'b0, -1, os, ost, od);
    tick();

    // asynchronous reset while waiting on the engine
    start = 1'b1;
    num_steps = 8'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre-reset busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset outputs",
        int'({layer_start, layer_idx, timestep, step_done, busy, done, timeout_err}), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int j = 0; j < 64; j++) dly_tab[j] = 2;
    run_job("after_reset", 1, 1'b0, 1'b0, -1, os, ost, od);
    tick();

    // randomized jobs against the timeline model
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(4, 1));
      sp = int'($urandom_range(1, 0));
      for (int j = 0; j < 64; j++) dly_tab[j] = int'($urandom_range(6, 1));
      run_job($sformatf("rand%0d", r), n, sp[0], 1'b0, -1, os, ost, od);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
